nonce_round_scheduler: RTL

//  Sequences LANES parallel hash lanes (nonce source -> concatenator -> micro-hash -> comparator) in lockstep rounds.

---
 rtl/nonce_round_scheduler.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/nonce_round_scheduler.sv
// nonce_round_scheduler: runs LANES hash lanes in lockstep rounds and reports the lowest hitting nonce.
// Define NONCE_SCHED_WDOG_EN to add the per-round stall watchdog, the WDOG_CYC parameter and the wdog_trip output.
module nonce_round_scheduler #(
    parameter int unsigned        LANES     = 3,
    parameter int unsigned        NONCE_W   = 32,
    parameter logic [NONCE_W-1:0] NONCE_MAX = {NONCE_W{1'b1}}
`ifdef NONCE_SCHED_WDOG_EN
    ,
    parameter int unsigned        WDOG_CYC  = 64
`endif
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic [LANES-1:0]         lane_done,
    input  logic [LANES-1:0]         lane_hit,
    output logic [LANES-1:0]         lane_start,
    output logic [LANES*NONCE_W-1:0] lane_nonce,
    output logic                     busy,
    output logic                     finished,
    output logic                     exhausted,
    output logic [NONCE_W-1:0]       nonce_out
`ifdef NONCE_SCHED_WDOG_EN
    ,
    output logic                     wdog_trip
`endif
);
    localparam int unsigned CMP_W = NONCE_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        DISPATCH,
        WAIT,
        FOUND,
        EXHAUSTED
    } state_t;

    state_t             state, state_nxt;
    logic [NONCE_W-1:0] base, base_nxt;
    logic [NONCE_W-1:0] win_nonce, win_nonce_nxt;
    logic [NONCE_W-1:0] win_off;
    logic [LANES-1:0]   done_mask, done_mask_nxt;
    logic [LANES-1:0]   hit_mask, hit_mask_nxt;
    logic [LANES-1:0]   active;
    logic               last_round;

`ifdef NONCE_SCHED_WDOG_EN
    localparam int unsigned WDOG_W = $clog2(WDOG_CYC + 1);
    logic [WDOG_W-1:0] wdog_cnt, wdog_cnt_nxt;
    logic              wdog_trip_nxt;
    logic              wdog_expired;

    assign wdog_expired = (wdog_cnt == WDOG_W'(WDOG_CYC - 1));
`endif

    // Range checks use one extra bit so base+i never wraps past NONCE_MAX.
    always_comb begin
        active = '0;
        for (int i = 0; i < LANES; i++) begin
            active[i] = (({1'b0, base} + CMP_W'(i)) <= {1'b0, NONCE_MAX});
        end
        last_round = (({1'b0, base} + CMP_W'(LANES)) > {1'b0, NONCE_MAX});
    end

    always_comb begin
        win_off = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (hit_mask[i]) begin
                win_off = NONCE_W'(i);
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        base_nxt      = base;
        done_mask_nxt = done_mask;
        hit_mask_nxt  = hit_mask;
        win_nonce_nxt = win_nonce;
`ifdef NONCE_SCHED_WDOG_EN
        wdog_cnt_nxt  = wdog_cnt;
        wdog_trip_nxt = wdog_trip;
`endif
        if (abort) begin
            state_nxt     = IDLE;
            base_nxt      = '0;
            done_mask_nxt = '0;
            hit_mask_nxt  = '0;
            win_nonce_nxt = '0;
`ifdef NONCE_SCHED_WDOG_EN
            wdog_cnt_nxt  = '0;
            wdog_trip_nxt = 1'b0;
`endif
        end else begin
            case (state)
                IDLE, FOUND, EXHAUSTED: begin
                    if (start) begin
                        state_nxt     = DISPATCH;
                        base_nxt      = '0;
                        win_nonce_nxt = '0;
`ifdef NONCE_SCHED_WDOG_EN
                        wdog_trip_nxt = 1'b0;
`endif
                    end
                end
                DISPATCH: begin
                    state_nxt     = WAIT;
                    done_mask_nxt = '0;
                    hit_mask_nxt  = '0;
`ifdef NONCE_SCHED_WDOG_EN
                    wdog_cnt_nxt  = '0;
`endif
                end
                WAIT: begin
                    // A hit only counts on a lane's first done of the round.
                    done_mask_nxt = done_mask | (lane_done & active);
                    hit_mask_nxt  = hit_mask | (lane_done & lane_hit & active & ~done_mask);
`ifdef NONCE_SCHED_WDOG_EN
                    wdog_cnt_nxt  = wdog_cnt + WDOG_W'(1);
`endif
                    if (done_mask == active) begin
                        if (|hit_mask) begin
                            state_nxt     = FOUND;
                            win_nonce_nxt = base + win_off;
                        end else if (last_round) begin
                            state_nxt = EXHAUSTED;
                        end else begin
                            state_nxt = DISPATCH;
                            base_nxt  = base + NONCE_W'(LANES);
                        end
                    end
`ifdef NONCE_SCHED_WDOG_EN
                    else if (wdog_expired) begin
                        state_nxt     = EXHAUSTED;
                        wdog_trip_nxt = 1'b1;
                    end
`endif
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            base      <= '0;
            done_mask <= '0;
            hit_mask  <= '0;
            win_nonce <= '0;
`ifdef NONCE_SCHED_WDOG_EN
            wdog_cnt  <= '0;
            wdog_trip <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            base      <= base_nxt;
            done_mask <= done_mask_nxt;
            hit_mask  <= hit_mask_nxt;
            win_nonce <= win_nonce_nxt;
`ifdef NONCE_SCHED_WDOG_EN
            wdog_cnt  <= wdog_cnt_nxt;
            wdog_trip <= wdog_trip_nxt;
`endif
        end
    end

    always_comb begin
        lane_nonce = '0;
        if (state != IDLE) begin
            for (int i = 0; i < LANES; i++) begin
                lane_nonce[i*NONCE_W +: NONCE_W] = base + NONCE_W'(i);
            end
        end
    end

    assign lane_start = (state == DISPATCH) ? active : '0;
    assign busy       = (state == DISPATCH) || (state == WAIT);
    assign finished   = (state == FOUND);
    assign exhausted  = (state == EXHAUSTED);
    assign nonce_out  = finished ? win_nonce : '0;

endmodule
